// File: rtl/pwl_coef_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : pwl_coef_fetch
//  Description : Splits a fixed-point sample into segment index and offset and
//                fetches that segment's slope/intercept for the interpolator.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwl_coef_fetch #(
  parameter int IW_IN    = 4,
  parameter int QW_IN    = 12,
  parameter int SEG_BITS = 2,
  parameter int IW_M     = 4,
  parameter int QW_M     = 12,
  parameter int IW_B     = 8,
  parameter int QW_B     = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [IW_IN+QW_IN-1:0]          u,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [IW_M+QW_M-1:0]            m,
  output logic [IW_IN-SEG_BITS+QW_IN:0]   x,
  output logic [IW_B+QW_B-1:0]            b,
  input  logic                            cfg_we,
  input  logic [SEG_BITS-1:0]             cfg_addr,
  input  logic [IW_M+QW_M-1:0]            cfg_m,
  input  logic [IW_B+QW_B-1:0]            cfg_b
);

  localparam int WL_IN = IW_IN + QW_IN;
  localparam int WL_M  = IW_M + QW_M;
  localparam int WL_B  = IW_B + QW_B;
  localparam int WL_X  = IW_IN - SEG_BITS + 1 + QW_IN;
  localparam int NSEG  = 1 << SEG_BITS;

  generate
    if (SEG_BITS < 1 || SEG_BITS > IW_IN) begin : g_bad_seg_bits
      $fatal(1, "pwl_coef_fetch: SEG_BITS must lie in 1..IW_IN");
    end
  endgenerate

  logic [WL_M-1:0]     tab_m_q [NSEG];
  logic [WL_B-1:0]     tab_b_q [NSEG];

  logic                s1_valid_q, s1_valid_d;
  logic [SEG_BITS-1:0] s1_idx_q,   s1_idx_d;
  logic [WL_X-1:0]     s1_x_q,     s1_x_d;
  logic                s2_valid_q, s2_valid_d;
  logic [WL_M-1:0]     m_q,        m_d;
  logic [WL_X-1:0]     x_q,        x_d;
  logic [WL_B-1:0]     b_q,        b_d;

  logic                s2_load;
  logic                s1_adv;
  logic                accept;

  always_comb begin
    s2_load    = !s2_valid_q || out_ready;
    s1_adv     = s1_valid_q && s2_load;
    in_ready   = !s1_valid_q || s2_load;
    accept     = in_valid && in_ready;

    s1_valid_d = s1_valid_q;
    s1_idx_d   = s1_idx_q;
    s1_x_d     = s1_x_q;
    s2_valid_d = s2_valid_q;
    m_d        = m_q;
    x_d        = x_q;
    b_d        = b_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_idx_d   = u[WL_IN-1 -: SEG_BITS];
      s1_x_d     = {1'b0, u[WL_IN-SEG_BITS-1:0]};
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      s2_valid_d = s1_valid_q;
    end

    // Table is read from its registered state, so a same-edge write lands after this read.
    if (s1_adv) begin
      m_d = tab_m_q[s1_idx_q];
      b_d = tab_b_q[s1_idx_q];
      x_d = s1_x_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s1_x_q     <= '0;
      s2_valid_q <= 1'b0;
      m_q        <= '0;
      x_q        <= '0;
      b_q        <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_idx_q   <= s1_idx_d;
      s1_x_q     <= s1_x_d;
      s2_valid_q <= s2_valid_d;
      m_q        <= m_d;
      x_q        <= x_d;
      b_q        <= b_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSEG; i++) begin
        tab_m_q[i] <= '0;
        tab_b_q[i] <= '0;
      end
    end else if (cfg_we) begin
      tab_m_q[cfg_addr] <= cfg_m;
      tab_b_q[cfg_addr] <= cfg_b;
    end
  end

  assign out_valid = s2_valid_q;
  assign m         = m_q;
  assign x         = x_q;
  assign b         = b_q;

endmodule
`default_nettype wire

// File: doc/pwl_coef_fetch.md
Name: pwl_coef_fetch

Overview:
- Upstream stage of the fixed-point linear interpolator (y = m*x + b). Produces the (m, x, b) triplet that the interpolator consumes.
- Splits a signed fixed-point input u into a segment index (top SEG_BITS bits) and an in-segment offset x.
- Fetches that segment's slope m and intercept b from a runtime-writable coefficient table.
- Two-stage valid/ready pipeline with full backpressure. Output formats match the interpolator's m, x and b inputs.

Parameters:
IW_IN, 4, integer width of u (includes sign)
QW_IN, 12, fractional width of u
SEG_BITS, 2, segment index width; 2**SEG_BITS table entries; legal range 1..IW_IN
IW_M, 4, integer width of m
QW_M, 12, fractional width of m
IW_B, 8, integer width of b
QW_B, 10, fractional width of b

Ports:
clk  in  1  sole clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  u is valid
in_ready  out  1  stage accepts u
u  in  IW_IN+QW_IN  signed input sample
out_valid  out  1  m/x/b valid
out_ready  in  1  downstream accepts
m  out  IW_M+QW_M  signed slope of selected segment
x  out  IW_IN-SEG_BITS+1+QW_IN  signed offset, format (IW_IN-SEG_BITS+1).QW_IN, MSB always 0
b  out  IW_B+QW_B  signed intercept of selected segment
cfg_we  in  1  table write strobe
cfg_addr  in  SEG_BITS  table entry to write
cfg_m  in  IW_M+QW_M  slope write data
cfg_b  in  IW_B+QW_B  intercept write data

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: out_valid=0, m=0, x=0, b=0, every table entry m=0 and b=0, both stage valids cleared. in_ready=1 in the first cycle after reset.
- Reset mid-operation: in-flight samples are discarded, not flushed. rst has priority over cfg_we in the same cycle.
- Index and offset split:
  - idx = u[WL_IN-1 -: SEG_BITS], treated as unsigned.
  - x = {1'b0, u[WL_IN-SEG_BITS-1:0]}, zero-extended. No rounding; the binary point is unchanged, so QW_X = QW_IN.
  - With defaults: idx 0 covers [0,4), 1 covers [4,8), 2 covers [-8,-4), 3 covers [-4,0).
- Stage 1 (S1):
  - Captures idx and x on in_valid && in_ready.
  - s1_valid set on capture; cleared when S1 advances without a new capture.
- Stage 2 (S2):
  - When S1 advances, registers m=table_m[idx], b=table_b[idx], and x.
  - out_valid = s2_valid.
- Advance and ready rules:
  - S2 loads when !s2_valid || out_ready.
  - S1 advances when s1_valid and S2 loads.
  - in_ready = !s1_valid || S2 can load. This is combinational from out_ready; there is no combinational path from in_valid to in_ready.
- Latency and throughput: 2 cycles from accepted u to out_valid with out_ready held high; throughput 1 sample/cycle.
- Stall: while out_valid && !out_ready, m/x/b hold stable. Both stages fill; in_ready=0 once S1 is full. No sample is dropped or duplicated.
- Table writes:
  - On cfg_we, the entry at cfg_addr is updated at the clock edge.
  - A sample moving S1→S2 in the same cycle reads the old value (read-before-write).
  - Samples already in S2 are never altered by later writes.
  - Writes are accepted regardless of handshake state.
- Bubbles: in_valid=0 inserts a bubble; out_valid drops for exactly one cycle, 2 cycles later.
- Elaboration checks: SEG_BITS<1 or SEG_BITS>IW_IN is a fatal elaboration error.

Test Plan:
1. Reset then single sample: write entry 1 with m=0x1800 (1.5) and b=0x0C80 (3.125). Apply u=0x4400 (4.25) with out_ready=1. Two cycles later: out_valid=1, m=0x1800, x=0x0400 (0.25), b=0x0C80. Feeding the interpolator must then give y=3.5.
2. Negative input: write entry 3 with m=0xF000 and b=0x0400. Apply u=0xF000 (-1.0). Expect m=0xF000, b=0x0400, x=0x3000.
3. Backpressure: stream 6 samples u=0x0000..0x0005 with out_ready=0 for cycles 3–7. Expect in_ready=0 once both stages are full, outputs held stable, all 6 x values delivered in order with no loss.
4. Write collision: in the same cycle a sample with idx 2 moves S1→S2 and cfg_we writes entry 2. That sample outputs the old m/b; the next idx-2 sample outputs the new m/b.
5. Reset mid-stream: with 2 samples in flight, assert rst for 1 cycle. Expect out_valid=0, the table zeroed, and the next sample emitting m=0, b=0.
6. Full throughput: 64 back-to-back samples with out_ready=1. Expect 64 outputs on consecutive cycles, each matching a reference model.
